// File: rtl/ama_riscv_fetch_unit.sv
// Instruction-fetch stage: PC generator, single outstanding IMEM read tracker
// and a circular fetch queue drained by decode through a valid/ready handshake.
module ama_riscv_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          IMEM_AW  = 14,
    parameter int          FQ_DEPTH = 4,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [31:0]                redirect_pc,
    input  logic                       restart,
    output logic                       imem_req,
    output logic [IMEM_AW-1:0]         imem_addr,
    input  logic [31:0]                imem_rdata,
    output logic                       out_valid,
    output logic [31:0]                out_inst,
    output logic [31:0]                out_pc,
    input  logic                       out_ready,
    output logic [$clog2(FQ_DEPTH):0]  fq_count
);

    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(FQ_DEPTH);

    logic [31:0]   pc_f;
    logic          infl_v;
    logic [31:0]   infl_pc;
    logic [31:0]   q_pc   [FQ_DEPTH];
    logic [31:0]   q_inst [FQ_DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;

    logic          flush;
    logic [31:0]   flush_target;
    logic [31:0]   issue_pc;
    logic [CW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    // Credit the outstanding read against queue space so a push can never overflow.
    assign flush        = restart | redirect_valid;
    assign flush_target = restart ? RESET_PC : {redirect_pc[31:2], 2'b00};
    assign occupancy    = {1'b0, count} + {{CW{1'b0}}, infl_v};
    assign issue        = rst_n & (flush | (occupancy < DEPTH_W));
    assign issue_pc     = flush ? flush_target : pc_f;

    assign imem_req  = issue;
    assign imem_addr = issue_pc[IMEM_AW+1:2];

    assign push = infl_v & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    assign out_valid = (count != '0);
    assign out_inst  = out_valid ? q_inst[rd_ptr] : NOP_INST;
    assign out_pc    = out_valid ? q_pc[rd_ptr]   : 32'h0000_0000;
    assign fq_count  = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_f    <= RESET_PC;
            infl_v  <= 1'b0;
            infl_pc <= 32'h0000_0000;
        end else begin
            infl_v <= issue;
            if (issue) begin
                pc_f    <= issue_pc + 32'd4;
                infl_pc <= issue_pc;
            end
        end
    end

    // A flush empties the queue and drops whatever read returns this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]   <= infl_pc;
            q_inst[wr_ptr] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
                     !(push && !pop && ({1'b0, count} == DEPTH_W)));

endmodule

// File: tb/tb_ama_riscv_fetch_unit.sv
// Self-checking bench for ama_riscv_fetch_unit: directed timing checks plus a
// randomized phase scored against the expected sequential PC stream per flush.
module tb_ama_riscv_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          IMEM_AW  = 14;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic               clk;
    logic               rst_n;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               restart;
    logic               imem_req;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_rdata;
    logic               out_valid;
    logic [31:0]        out_inst;
    logic [31:0]        out_pc;
    logic               out_ready;
    logic [2:0]         fq_count;

    int checks   = 0;
    int errors   = 0;
    int accepted = 0;
    logic [31:0] exp_q[$];

    ama_riscv_fetch_unit #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW),
        .FQ_DEPTH (FQ_DEPTH),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .restart        (restart),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .fq_count       (fq_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction content is a pure function of the word address.
    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        logic [13:0] w;
        w = pc[15:2];
        return {w, 2'b11, w[7:0], 8'h5A};
    endfunction

    always @(posedge clk) begin
        if (imem_req) imem_rdata <= inst_of({16'h0, imem_addr, 2'b00});
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // After a flush the accepted stream must be target, target+4, ... (mod 2^32).
    task automatic fill_expected(input logic [31:0] target);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(target + 32'(4 * i));
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc,
                                 input logic rs, input logic rdy);
        redirect_valid = rv;
        redirect_pc    = rpc;
        restart        = rs;
        out_ready      = rdy;
        if (rv || rs) fill_expected(rs ? RESET_PC : {rpc[31:2], 2'b00});
    endtask

    task automatic drive_cycle(input logic rv, input logic [31:0] rpc,
                               input logic rs, input logic rdy);
        @(posedge clk);
        #1;
        applyStimulus(rv, rpc, rs, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic rdy);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, rdy);
        fill_expected(RESET_PC);
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
        checkOutput("rst_out_inst", out_inst, NOP_INST);
        checkOutput("rst_out_pc", out_pc, 32'h0);
        checkOutput("rst_fq_count", 32'(fq_count), 32'h0);
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Scoreboard monitor: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready && !(redirect_valid || restart)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL sb_unexpected: got pc 0x%08h, expected no output", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                checkOutput("sb_pc", out_pc, e);
                checkOutput("sb_inst", out_inst, inst_of(e));
                accepted++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int reqs;
        int since_flush;
        logic rv, rs, rdy;
        logic [31:0] rpc;

        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        restart = 1'b0;
        out_ready = 1'b0;

        // Reset release and gap-free streaming
        do_reset(1'b1);
        checkOutput("c0_imem_req", 32'(imem_req), 32'h1);
        checkOutput("c0_imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("c0_out_valid", 32'(out_valid), 32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("c1_imem_addr", 32'(imem_addr), 32'h1);
        checkOutput("c1_out_valid", 32'(out_valid), 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checkOutput("stream_valid", 32'(out_valid), 32'h1);
            checkOutput("stream_pc", out_pc, 32'(4 * i));
            checkOutput("stream_addr", 32'(imem_addr), 32'(i + 2));
        end

        // Backpressure from release
        do_reset(1'b0);
        reqs = int'(imem_req);
        for (int i = 0; i < 9; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
            reqs += int'(imem_req);
        end
        checkOutput("bp_requests", 32'(reqs), 32'd4);
        checkOutput("bp_fq_count", 32'(fq_count), 32'd4);
        checkOutput("bp_imem_req", 32'(imem_req), 32'h0);
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checkOutput("bp_drain_valid", 32'(out_valid), 32'h1);
            checkOutput("bp_drain_pc", out_pc, 32'(4 * i));
        end

        // Redirect while streaming
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h0000_0103, 1'b0, 1'b1);
        checkOutput("redir_imem_addr", 32'(imem_addr), 32'h40);
        checkOutput("redir_imem_req", 32'(imem_req), 32'h1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("redir_bubble_valid", 32'(out_valid), 32'h0);
        checkOutput("redir_bubble_inst", out_inst, NOP_INST);
        checkOutput("redir_bubble_pc", out_pc, 32'h0);
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
            checkOutput("redir_stream_pc", out_pc, 32'h100 + 32'(4 * i));
        end

        // Redirect coinciding with a pop on a full queue
        do_reset(1'b0);
        for (int i = 0; i < 20 && fq_count != 3'd4; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("full_wait_fq_count", 32'(fq_count), 32'd4);
        drive_cycle(1'b1, 32'h0000_0200, 1'b0, 1'b1);
        checkOutput("full_redir_addr", 32'(imem_addr), 32'h80);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("full_redir_fq_count", 32'(fq_count), 32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("full_redir_pc", out_pc, 32'h200);

        // Restart wins over a simultaneous redirect
        for (int i = 0; i < 2; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h0000_0300, 1'b1, 1'b1);
        checkOutput("restart_addr", 32'(imem_addr), (RESET_PC >> 2) & 32'h3FFF);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("restart_pc0", out_pc, RESET_PC);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("restart_pc1", out_pc, RESET_PC + 32'd4);

        // Asynchronous reset between edges with a read outstanding
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        fill_expected(RESET_PC);
        #1;
        checkOutput("async_out_valid", 32'(out_valid), 32'h0);
        checkOutput("async_fq_count", 32'(fq_count), 32'h0);
        checkOutput("async_imem_req", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("async_c0_addr", 32'(imem_addr), (RESET_PC >> 2) & 32'h3FFF);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("async_c1_valid", 32'(out_valid), 32'h0);
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("async_first_pc", out_pc, RESET_PC);

        // Randomized traffic: stalls, redirects (some near the 2^32 wrap), restarts
        accepted = 0;
        since_flush = 0;
        for (int n = 0; n < 1500; n++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rs  = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 29) == 0) || (since_flush >= 40);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h1F)) : $urandom;
            drive_cycle(rv, rpc, rs, rdy);
            since_flush = (rv || rs) ? 0 : since_flush + 1;
            checkOutput("rand_fq_bound", 32'(fq_count <= 3'd4), 32'h1);
        end
        drive_cycle(1'b0, 32'h0, 1'b0, 1'b0);
        checkOutput("rand_progress", 32'(accepted >= 300), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
